// File: rtl/rv_dmem_pkg.sv
// Shared decode constants and sizing helper for the rv_dmem data memory.
package rv_dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int unsigned idx_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rv_dmem_lane_align.sv
// Combinational RV32I load/store lane steering: byte enables, store
// replication, load extraction/extension and misalign/illegal detection.
module rv_dmem_lane_align
  import rv_dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misal;
  logic        illegal;

  always_comb begin
    byte_sel   = rdata_word[{offset, 3'b000} +: 8];
    half_sel   = rdata_word[{offset[1], 4'b0000} +: 16];
    be         = '0;
    store_word = '0;
    load_data  = '0;
    misal      = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << offset;
        store_word = {4{wdata[7:0]}};
        load_data  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        illegal   = we;
        be        = 4'b0001 << offset;
        load_data = {24'b0, byte_sel};
      end
      F3_H: begin
        misal      = offset[0];
        be         = offset[1] ? 4'b1100 : 4'b0011;
        store_word = {2{wdata[15:0]}};
        load_data  = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        illegal   = we;
        misal     = offset[0];
        be        = offset[1] ? 4'b1100 : 4'b0011;
        load_data = {16'b0, half_sel};
      end
      F3_W: begin
        misal      = (offset != 2'b00);
        be         = 4'b1111;
        store_word = wdata;
        load_data  = rdata_word;
      end
      default: illegal = 1'b1;
    endcase
    err = illegal | misal;
    // Enables only ever describe a legal store.
    if (err || !we) be = '0;
  end

endmodule

// File: rtl/rv_dmem_bytelane.sv
// RV32I data memory with byte-lane stores, extended loads and a post-reset
// clear sequencer. Optional macro DMEM_STORE_FWD_EN: buffered store write-back
// with a write-first bypass on the read port.
module rv_dmem_bytelane
  import rv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic [0:0]       state;
  logic [IDX_W-1:0] clr_ptr;
  logic [IDX_W-1:0] idx;
  logic [1:0]       offset;
  logic             accept;
  logic             store_ok;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      rd_word;
  logic [3:0]       be;
  logic [31:0]      st_word;
  logic [31:0]      ld_data;
  logic             err;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  assign idx       = req_addr[IDX_W+1:2];
  assign offset    = req_addr[1:0];
  assign req_ready = (state == ST_READY);
  assign init_busy = (state == ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign store_ok  = accept && req_we && !err;

  rv_dmem_lane_align u_align (
    .funct3     (req_funct3),
    .we         (req_we),
    .offset     (offset),
    .wdata      (req_wdata),
    .rdata_word (rd_word),
    .be         (be),
    .store_word (st_word),
    .load_data  (ld_data),
    .err        (err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == IDX_W'(DEPTH - 1)) state <= ST_READY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (req_we || err) ? '0 : ld_data;
      end
    end
  end

`ifdef DMEM_STORE_FWD_EN
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic [3:0]       wb_be;
  logic [31:0]      wb_data;

  // Stores land in the array one cycle late; reads merge the pending lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_be    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= store_ok;
      wb_idx   <= idx;
      wb_be    <= be;
      wb_data  <= st_word;
    end
  end

  always_comb begin
    rd_word = mem[idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (wb_valid && (wb_idx == idx) && wb_be[i]) rd_word[8*i +: 8] = wb_data[8*i +: 8];
    end
  end

  assign wr_en   = wb_valid;
  assign wr_idx  = wb_idx;
  assign wr_be   = wb_be;
  assign wr_data = wb_data;
`else
  assign rd_word = mem[idx];
  assign wr_en   = store_ok;
  assign wr_idx  = idx;
  assign wr_be   = be;
  assign wr_data = st_word;
`endif

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv_dmem_bytelane.sv
// Self-checking bench for rv_dmem_bytelane: directed steps plus randomized
// traffic against a byte-addressed reference model.
module tb_rv_dmem_bytelane;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [1024];
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  rv_dmem_bytelane #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_busy  (init_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned access_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = (f3 == 0 || f3 == 1 || f3 == 2) || ((f3 == 4 || f3 == 5) && !we);
    return !legal || ((addr % access_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a;
    int unsigned size;
    longint v;
    a = addr % 1024;
    size = access_size(f3);
    v = 0;
    for (int unsigned k = 0; k < size; k++) v += longint'(model[a + k]) << (8 * k);
    if (f3 < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned a;
    a = addr % 1024;
    for (int unsigned k = 0; k < access_size(f3); k++) model[a + k] = 8'(wd >> (8 * k));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    last_rdata = '0;
    last_err   = 1'b0;
  endtask

  // One request per call; consecutive calls are back-to-back cycles.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    logic [31:0] exp;
    bit          e;
    e   = model_err(we, f3, addr);
    exp = (e || we) ? 32'h0 : model_load(f3, addr);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    if (!e && we) model_store(f3, addr, wd);
    check({tag, ".vld"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, ".err"}, {31'b0, rsp_err}, {31'b0, e});
    check({tag, ".rdata"}, rsp_rdata, exp);
    last_rdata = exp;
    last_err   = e;
    req_valid  = 1'b0;
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".vld"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, ".hold_rdata"}, rsp_rdata, last_rdata);
    check({tag, ".hold_err"}, {31'b0, rsp_err}, {31'b0, last_err});
  endtask

  // Release reset with requests pending and count the clear sequence length.
  task automatic run_clear(input string tag);
    int busy;
    int leak;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0000;
    req_wdata  = 32'hFFFF_FFFF;
    rst  = 1'b1;
    busy = 0;
    leak = 0;
    while (init_busy && busy < 400) begin
      if (rsp_valid || req_ready) leak++;
      @(posedge clk);
      #1;
      busy++;
    end
    req_valid = 1'b0;
    check({tag, ".busy_cycles"}, 32'(busy), 32'd256);
    check({tag, ".clear_leak"}, 32'(leak), 32'd0);
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    model_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, ".busy"}, {31'b0, init_busy}, 32'd1);
    check({tag, ".vld"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, ".rdata"}, rsp_rdata, 32'd0);
    check({tag, ".err"}, {31'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit          we;
    int          leak;

    model_clear();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    run_clear("clear0");

    do_req(1'b0, 3'b010, 32'h0000_03FC, 32'h0, "lw_3fc");

    do_req(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, "sw_10");
    do_req(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AA, "sb_11");
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, "lw_10");
    do_req(1'b0, 3'b000, 32'h0000_0011, 32'h0, "lb_11");
    do_req(1'b0, 3'b100, 32'h0000_0011, 32'h0, "lbu_11");
    do_req(1'b1, 3'b001, 32'h0000_0012, 32'h0000_8001, "sh_12");
    do_req(1'b0, 3'b001, 32'h0000_0012, 32'h0, "lh_12");
    do_req(1'b0, 3'b101, 32'h0000_0012, 32'h0, "lhu_12");
    do_req(1'b0, 3'b010, 32'h0000_0013, 32'h0, "lw_13_misal");
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, "lw_10_after");
    do_req(1'b1, 3'b010, 32'h0000_0014, 32'h0BAD_F00D, "sw_14");
    do_req(1'b1, 3'b001, 32'h0000_0015, 32'h0000_FFFF, "sh_15_misal");
    do_req(1'b0, 3'b010, 32'h0000_0014, 32'h0, "lw_14");
    do_req(1'b0, 3'b011, 32'h0000_0010, 32'h0, "f3_011");
    do_req(1'b1, 3'b100, 32'h0000_0010, 32'h0000_0077, "sbu_illegal");
    idle("idle_err");
    do_req(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, "sw_20");
    do_req(1'b0, 3'b010, 32'h0000_0020, 32'h0, "lw_20_b2b");
    idle("idle_b2b");
    do_req(1'b1, 3'b010, 32'h0000_0400, 32'h5A5A_5A5A, "sw_wrap");
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, "lw_0_wrap");
    do_req(1'b0, 3'b000, 32'hFFFF_FC03, 32'h0, "lb_wrap_hi");

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle("rnd_idle");
      end else begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = $urandom;
        // Most traffic targets the first 16 words to create read-after-write hits.
        if ($urandom_range(0, 3) != 0) a = (a & 32'hFFFF_FC00) | (a & 32'h0000_003F);
        if ($urandom_range(0, 3) != 0) a = a & ~(32'(access_size(f3)) - 32'd1);
        do_req(we, f3, a, $urandom, "rnd");
      end
    end

    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_traffic");
    run_clear("clear1");
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_0001, "sw_pre_abort");

    rst = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b1;
    leak = 0;
    for (int c = 0; c < 100; c++) begin
      if (rsp_valid || req_ready || !init_busy) leak++;
      @(posedge clk);
      #1;
    end
    check("partial_clear_leak", 32'(leak), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_midclear");
    run_clear("clear2");
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, "lw_10_cleared");
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, "lw_0_cleared");
    idle("idle_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
